cw305_reg_arbiter: RTL and testbench
====================================

CW305_REG_ARBITER -- requirements
Module: cw305_reg_arbiter

Interface
REQ-001 Parameters SHALL be: pADDR_WIDTH 21 (full address width); pBYTECNT_SIZE 7 (byte-count field width); pGUARD 2 (idle cycles after USB activity before B is granted, ≥1); pSTARVE_MAX 255 (B wait-cycle threshold, 8-bit counter).
REQ-002 usb_clk in 1: single clock; one clock only; all logic on its rising edge.
REQ-003 rst_n in 1: synchronous, active-low reset.
REQ-004 u_address in [pADDR_WIDTH-1:pBYTECNT_SIZE], u_bytecnt in [pBYTECNT_SIZE-1:0], u_datao in 8, u_read in 1, u_write in 1: USB-frontend register request.
REQ-005 u_busy_early in 1: USB early warning; u_read/u_write are never asserted unless u_busy_early was high the previous cycle.
REQ-006 u_datai out 8: read data to the USB frontend; equals reg_datai combinationally.
REQ-007 b_req in 1, b_we in 1, b_address/b_bytecnt (widths as u_*), b_wdata in 8: internal-master single-byte request; held stable until b_gnt.
REQ-008 b_gnt out 1: single-cycle pulse, request accepted; b_rvalid out 1: single-cycle pulse, b_rdata out 8 valid.
REQ-009 reg_address, reg_bytecnt, reg_datao, reg_read, reg_write out; reg_datai in 8: shared register-bank port; bank returns data one cycle after reg_read.
REQ-010 starve_flag out 1: sticky starvation status; starve_clr in 1: clears it.

Function
REQ-011 FSM states SHALL be IDLE, USB, GUARD, B_WR, B_RD1, B_RD2.
REQ-012 In IDLE, USB, GUARD: reg_* SHALL equal u_* combinationally (zero added latency); in B_* states reg_* SHALL carry B fields, reg_datao=b_wdata.
REQ-013 IDLE: u_busy_early|u_read|u_write -> USB; else b_req&b_we -> B_WR; else b_req&~b_we -> B_RD1; else stay.
REQ-014 USB: stay while u_busy_early|u_read|u_write; else -> GUARD with guard counter loaded pGUARD-1.
REQ-015 GUARD: any USB activity -> USB; counter zero -> IDLE; else decrement. B is never granted in USB or GUARD.
REQ-016 B_WR: reg_write=1, b_gnt=1 for exactly this cycle; next IDLE, or USB if u_busy_early.
REQ-017 B_RD1: reg_read=1 with B address; u_busy_early -> USB (abort, no b_gnt, request retried later); else -> B_RD2.
REQ-018 B_RD2: B address held, reg_read=1, b_gnt=1; reg_datai registered into b_rdata; b_rvalid=1 the following cycle; next as REQ-016.
REQ-019 USB SHALL have absolute priority; a USB request is never delayed or dropped.
REQ-020 Starve counter SHALL increment each cycle b_req=1 and b_gnt=0, saturate at pSTARVE_MAX, clear when b_req=0 or b_gnt=1.
REQ-021 starve_flag SHALL set when counter reaches pSTARVE_MAX; clears on starve_clr; set wins if both occur in the same cycle.
REQ-022 b_rdata SHALL hold its value until the next completed B read.

Reset
REQ-023 When rst_n=0 at a clock edge: state IDLE, guard counter 0, starve counter 0, starve_flag 0, b_rvalid 0, b_rdata 0, b_gnt 0.
REQ-024 Reset mid-B-transaction SHALL abandon it with no b_gnt/b_rvalid; the master re-presents the request.

Structure
REQ-025 The FSM state enum and default parameter constants SHALL live in a shared package cw305_reg_pkg.
REQ-026 The starvation counter/flag SHALL be one sub-module, cw305_starve_mon.
REQ-027 Combinational output muxing only; no registers on the USB path.

Verification
REQ-028 USB write 0xA5 to reg 0x12 byte 3, b_req idle -> reg_write=1 same cycle as u_write, reg_datao=0xA5, no B grant.
REQ-029 b_req write 0x3C, no USB, pGUARD=2 -> B_WR one cycle after request, b_gnt pulse, reg_write=1 once.
REQ-030 B read, bank returns 0x77 -> b_gnt in B_RD2, b_rvalid one cycle later with b_rdata=0x77.
REQ-031 u_busy_early rises during B_RD1 -> abort, USB served unaltered, B read re-issued ≥pGUARD+1 cycles after USB ends, completes once.
REQ-032 Continuous USB traffic for 300 cycles with b_req high -> starve_flag=1 after 255 waiting cycles; starve_clr with continued traffic -> flag reasserts same cycle (set wins).
REQ-033 rst_n low during B_RD2 -> no b_rvalid, all outputs at reset values next cycle.

Source files
------------

// File: rtl/cw305_reg_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cw305_reg_pkg
//  Description : Shared arbiter state encoding and default parameter values
//                for the CW305 register-bank arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
package cw305_reg_pkg;

  localparam int c_ADDR_WIDTH   = 21;
  localparam int c_BYTECNT_SIZE = 7;
  localparam int c_GUARD        = 2;
  localparam int c_STARVE_MAX   = 255;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    USB   = 3'd1,
    GUARD = 3'd2,
    B_WR  = 3'd3,
    B_RD1 = 3'd4,
    B_RD2 = 3'd5
  } arb_state_e;

  // True for the states in which the internal master owns the bank port.
  function automatic logic is_b_state(arb_state_e s);
    return (s == B_WR) || (s == B_RD1) || (s == B_RD2);
  endfunction

endpackage
`default_nettype wire

// File: rtl/cw305_starve_mon.sv
`default_nettype none
// ============================================================================
//  Module      : cw305_starve_mon
//  Description : Counts consecutive cycles the internal master waits for a
//                grant and raises a sticky starvation flag at the threshold.
//  Revision    : 1.0 - initial release
// ============================================================================
module cw305_starve_mon #(
  parameter int pSTARVE_MAX = 255
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic req_i,
  input  logic gnt_i,
  input  logic clr_i,
  output logic flag_o
);

  localparam int            CW    = $clog2(pSTARVE_MAX + 1);
  localparam logic [CW-1:0] c_MAX = CW'(pSTARVE_MAX);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          flag_q, flag_d;

  // Next wait count (saturating) and flag; a set on the same cycle as a clear wins.
  always_comb begin
    cnt_d  = cnt_q;
    flag_d = flag_q;
    if (!req_i || gnt_i) begin
      cnt_d = '0;
    end else if (cnt_q != c_MAX) begin
      cnt_d = cnt_q + CW'(1);
    end
    if (cnt_d == c_MAX) begin
      flag_d = 1'b1;
    end else if (clr_i) begin
      flag_d = 1'b0;
    end
  end

  // Wait counter and sticky flag registers.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q  <= '0;
      flag_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      flag_q <= flag_d;
    end
  end

  assign flag_o = flag_q;

endmodule
`default_nettype wire

// File: rtl/cw305_reg_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : cw305_reg_arbiter
//  Description : Shares the CW305 register-bank port between the USB frontend
//                (absolute priority, zero added latency) and an internal
//                single-byte master that is only served while USB is quiet.
//  Revision    : 1.0 - initial release
// ============================================================================
module cw305_reg_arbiter
  import cw305_reg_pkg::*;
#(
  parameter int pADDR_WIDTH   = c_ADDR_WIDTH,
  parameter int pBYTECNT_SIZE = c_BYTECNT_SIZE,
  parameter int pGUARD        = c_GUARD,
  parameter int pSTARVE_MAX   = c_STARVE_MAX
) (
  input  logic                               usb_clk,
  input  logic                               rst_n,
  // USB frontend
  input  logic [pADDR_WIDTH-1:pBYTECNT_SIZE] u_address,
  input  logic [pBYTECNT_SIZE-1:0]           u_bytecnt,
  input  logic [7:0]                         u_datao,
  input  logic                               u_read,
  input  logic                               u_write,
  input  logic                               u_busy_early,
  output logic [7:0]                         u_datai,
  // Internal master
  input  logic                               b_req,
  input  logic                               b_we,
  input  logic [pADDR_WIDTH-1:pBYTECNT_SIZE] b_address,
  input  logic [pBYTECNT_SIZE-1:0]           b_bytecnt,
  input  logic [7:0]                         b_wdata,
  output logic                               b_gnt,
  output logic                               b_rvalid,
  output logic [7:0]                         b_rdata,
  // Register bank
  output logic [pADDR_WIDTH-1:pBYTECNT_SIZE] reg_address,
  output logic [pBYTECNT_SIZE-1:0]           reg_bytecnt,
  output logic [7:0]                         reg_datao,
  output logic                               reg_read,
  output logic                               reg_write,
  input  logic [7:0]                         reg_datai,
  // Starvation status
  output logic                               starve_flag,
  input  logic                               starve_clr
);

  localparam int            GW           = (pGUARD > 1) ? $clog2(pGUARD) : 1;
  localparam logic [GW-1:0] c_GUARD_LOAD = GW'(pGUARD - 1);

  arb_state_e    state_q;
  logic [GW-1:0] guard_q;
  logic          b_rvalid_q;
  logic [7:0]    b_rdata_q;
  logic          usb_act;

  assign usb_act = u_busy_early | u_read | u_write;

  // Arbitration FSM plus the read-return registers for the internal master.
  always_ff @(posedge usb_clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      guard_q    <= '0;
      b_rvalid_q <= 1'b0;
      b_rdata_q  <= '0;
    end else begin
      b_rvalid_q <= (state_q == B_RD2);
      if (state_q == B_RD2) begin
        b_rdata_q <= reg_datai;
      end
      case (state_q)
        IDLE: begin
          if (usb_act)          state_q <= USB;
          else if (b_req && b_we) state_q <= B_WR;
          else if (b_req)       state_q <= B_RD1;
        end
        USB: begin
          if (!usb_act) begin
            state_q <= GUARD;
            guard_q <= c_GUARD_LOAD;
          end
        end
        GUARD: begin
          if (usb_act)             state_q <= USB;
          else if (guard_q == '0)  state_q <= IDLE;
          else                     guard_q <= guard_q - GW'(1);
        end
        // A read aborted here leaves b_gnt low, so the master simply retries.
        B_RD1:       state_q <= usb_act ? USB : B_RD2;
        B_WR, B_RD2: state_q <= usb_act ? USB : IDLE;
        default:     state_q <= IDLE;
      endcase
    end
  end

  // Bank-port mux: USB passes straight through unless the master owns the port.
  always_comb begin
    reg_address = u_address;
    reg_bytecnt = u_bytecnt;
    reg_datao   = u_datao;
    reg_read    = u_read;
    reg_write   = u_write;
    b_gnt       = (state_q == B_WR) || (state_q == B_RD2);
    if (is_b_state(state_q)) begin
      reg_address = b_address;
      reg_bytecnt = b_bytecnt;
      reg_datao   = b_wdata;
      reg_read    = (state_q != B_WR);
      reg_write   = (state_q == B_WR);
    end
  end

  assign u_datai  = reg_datai;
  assign b_rvalid = b_rvalid_q;
  assign b_rdata  = b_rdata_q;

  cw305_starve_mon #(
    .pSTARVE_MAX (pSTARVE_MAX)
  ) u_starve_mon (
    .clk_i  (usb_clk),
    .rst_ni (rst_n),
    .req_i  (b_req),
    .gnt_i  (b_gnt),
    .clr_i  (starve_clr),
    .flag_o (starve_flag)
  );

endmodule
`default_nettype wire

// File: tb/tb_cw305_reg_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cw305_reg_arbiter
//  Description : Directed, table-driven bench for cw305_reg_arbiter with
//                hand-written sequences for abort, starvation and reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cw305_reg_arbiter;

  logic        usb_clk = 1'b0;
  logic        rst_n;
  logic [13:0] u_address, b_address, reg_address;
  logic [6:0]  u_bytecnt, b_bytecnt, reg_bytecnt;
  logic [7:0]  u_datao, u_datai, b_wdata, b_rdata, reg_datao, reg_datai;
  logic        u_read, u_write, u_busy_early;
  logic        b_req, b_we, b_gnt, b_rvalid;
  logic        reg_read, reg_write, starve_flag, starve_clr;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 usb_clk = ~usb_clk;

  cw305_reg_arbiter dut (
    .usb_clk      (usb_clk),
    .rst_n        (rst_n),
    .u_address    (u_address),
    .u_bytecnt    (u_bytecnt),
    .u_datao      (u_datao),
    .u_read       (u_read),
    .u_write      (u_write),
    .u_busy_early (u_busy_early),
    .u_datai      (u_datai),
    .b_req        (b_req),
    .b_we         (b_we),
    .b_address    (b_address),
    .b_bytecnt    (b_bytecnt),
    .b_wdata      (b_wdata),
    .b_gnt        (b_gnt),
    .b_rvalid     (b_rvalid),
    .b_rdata      (b_rdata),
    .reg_address  (reg_address),
    .reg_bytecnt  (reg_bytecnt),
    .reg_datao    (reg_datao),
    .reg_read     (reg_read),
    .reg_write    (reg_write),
    .reg_datai    (reg_datai),
    .starve_flag  (starve_flag),
    .starve_clr   (starve_clr)
  );

  typedef struct packed {
    logic       busy, rd, wr;
    logic [13:0] uaddr;
    logic [7:0]  udata;
    logic       breq, bwe;
    logic [13:0] baddr;
    logic [7:0]  bwdata, rdatai;
    logic       e_rd, e_wr;
    logic [13:0] e_addr;
    logic [6:0]  e_bc;
    logic [7:0]  e_datao;
    logic       e_gnt, e_rvalid;
    logic [7:0]  e_rdata;
  } vec_t;

  vec_t vecs [0:13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic cyc_drive();
    @(posedge usb_clk);
    #1;
  endtask

  initial begin
    int gcnt, gfirst, rvcnt, rvfirst, rdcnt;
    logic drop;

    // Cycle-by-cycle vectors; comment shows the arbiter state for that row.
    //             busy rd  wr  uaddr    udata  breq bwe baddr   bwdata rdatai | rd  wr  addr     bc    datao  gnt rv  rdata
    vecs[0]  = '{1'b0,1'b0,1'b0,14'h12,8'h00, 1'b0,1'b0,14'h00,8'h00,8'h00, 1'b0,1'b0,14'h12,7'd3,8'h00, 1'b0,1'b0,8'h00}; // IDLE
    vecs[1]  = '{1'b1,1'b0,1'b0,14'h12,8'h00, 1'b0,1'b0,14'h00,8'h00,8'h00, 1'b0,1'b0,14'h12,7'd3,8'h00, 1'b0,1'b0,8'h00}; // IDLE
    vecs[2]  = '{1'b1,1'b0,1'b1,14'h12,8'hA5, 1'b0,1'b0,14'h00,8'h00,8'h00, 1'b0,1'b1,14'h12,7'd3,8'hA5, 1'b0,1'b0,8'h00}; // USB
    vecs[3]  = '{1'b0,1'b0,1'b0,14'h12,8'h00, 1'b0,1'b0,14'h00,8'h00,8'h00, 1'b0,1'b0,14'h12,7'd3,8'h00, 1'b0,1'b0,8'h00}; // USB
    vecs[4]  = '{1'b0,1'b0,1'b0,14'h12,8'h00, 1'b1,1'b1,14'h05,8'h3C,8'h00, 1'b0,1'b0,14'h12,7'd3,8'h00, 1'b0,1'b0,8'h00}; // GUARD
    vecs[5]  = '{1'b0,1'b0,1'b0,14'h12,8'h00, 1'b1,1'b1,14'h05,8'h3C,8'h00, 1'b0,1'b0,14'h12,7'd3,8'h00, 1'b0,1'b0,8'h00}; // GUARD
    vecs[6]  = '{1'b0,1'b0,1'b0,14'h12,8'h00, 1'b1,1'b1,14'h05,8'h3C,8'h00, 1'b0,1'b0,14'h12,7'd3,8'h00, 1'b0,1'b0,8'h00}; // IDLE
    vecs[7]  = '{1'b0,1'b0,1'b0,14'h12,8'h00, 1'b1,1'b1,14'h05,8'h3C,8'h00, 1'b0,1'b1,14'h05,7'd1,8'h3C, 1'b1,1'b0,8'h00}; // B_WR
    vecs[8]  = '{1'b0,1'b0,1'b0,14'h12,8'h00, 1'b0,1'b0,14'h05,8'h3C,8'h00, 1'b0,1'b0,14'h12,7'd3,8'h00, 1'b0,1'b0,8'h00}; // IDLE
    vecs[9]  = '{1'b0,1'b0,1'b0,14'h12,8'h00, 1'b1,1'b0,14'h07,8'h00,8'h00, 1'b0,1'b0,14'h12,7'd3,8'h00, 1'b0,1'b0,8'h00}; // IDLE
    vecs[10] = '{1'b0,1'b0,1'b0,14'h12,8'h00, 1'b1,1'b0,14'h07,8'h00,8'h00, 1'b1,1'b0,14'h07,7'd1,8'h00, 1'b0,1'b0,8'h00}; // B_RD1
    vecs[11] = '{1'b0,1'b0,1'b0,14'h12,8'h00, 1'b1,1'b0,14'h07,8'h00,8'h77, 1'b1,1'b0,14'h07,7'd1,8'h00, 1'b1,1'b0,8'h00}; // B_RD2
    vecs[12] = '{1'b0,1'b0,1'b0,14'h12,8'h00, 1'b0,1'b0,14'h07,8'h00,8'h00, 1'b0,1'b0,14'h12,7'd3,8'h00, 1'b0,1'b1,8'h77}; // IDLE
    vecs[13] = '{1'b0,1'b0,1'b0,14'h12,8'h00, 1'b0,1'b0,14'h07,8'h00,8'h00, 1'b0,1'b0,14'h12,7'd3,8'h00, 1'b0,1'b0,8'h77}; // IDLE

    // ---------------- reset ----------------
    rst_n = 1'b0; u_address = '0; u_bytecnt = 7'd3; u_datao = '0; u_read = 1'b0;
    u_write = 1'b0; u_busy_early = 1'b0; b_req = 1'b0; b_we = 1'b0; b_address = '0;
    b_bytecnt = 7'd1; b_wdata = '0; reg_datai = '0; starve_clr = 1'b0;
    repeat (2) @(posedge usb_clk);
    @(negedge usb_clk);
    chk("rst_gnt", b_gnt, 0);
    chk("rst_rvalid", b_rvalid, 0);
    chk("rst_rdata", b_rdata, 0);
    chk("rst_flag", starve_flag, 0);
    chk("rst_regrd", reg_read, 0);
    chk("rst_regwr", reg_write, 0);
    @(posedge usb_clk); #1 rst_n = 1'b1;

    // ---------------- table ----------------
    for (int i = 0; i < 14; i++) begin
      cyc_drive();
      u_busy_early = vecs[i].busy; u_read = vecs[i].rd; u_write = vecs[i].wr;
      u_address = vecs[i].uaddr; u_datao = vecs[i].udata;
      b_req = vecs[i].breq; b_we = vecs[i].bwe; b_address = vecs[i].baddr;
      b_wdata = vecs[i].bwdata; reg_datai = vecs[i].rdatai;
      @(negedge usb_clk);
      chk($sformatf("row%0d_rd", i),     reg_read,    vecs[i].e_rd);
      chk($sformatf("row%0d_wr", i),     reg_write,   vecs[i].e_wr);
      chk($sformatf("row%0d_addr", i),   reg_address, vecs[i].e_addr);
      chk($sformatf("row%0d_bc", i),     reg_bytecnt, vecs[i].e_bc);
      chk($sformatf("row%0d_datao", i),  reg_datao,   vecs[i].e_datao);
      chk($sformatf("row%0d_gnt", i),    b_gnt,       vecs[i].e_gnt);
      chk($sformatf("row%0d_rvalid", i), b_rvalid,    vecs[i].e_rvalid);
      chk($sformatf("row%0d_rdata", i),  b_rdata,     vecs[i].e_rdata);
      chk($sformatf("row%0d_udatai", i), u_datai,     vecs[i].rdatai);
    end

    // ---------------- B read aborted by USB ----------------
    cyc_drive(); b_req = 1'b1; b_we = 1'b0; b_address = 14'h09;
    @(negedge usb_clk); chk("ab_idle_gnt", b_gnt, 0);
    cyc_drive(); u_busy_early = 1'b1;
    @(negedge usb_clk);
    chk("ab_rd1_rd", reg_read, 1);
    chk("ab_rd1_addr", reg_address, 14'h09);
    chk("ab_rd1_gnt", b_gnt, 0);
    cyc_drive(); u_read = 1'b1; u_address = 14'h12; reg_datai = 8'h44;
    @(negedge usb_clk);
    chk("ab_usb_rd", reg_read, 1);
    chk("ab_usb_addr", reg_address, 14'h12);
    chk("ab_usb_gnt", b_gnt, 0);
    chk("ab_usb_udatai", u_datai, 8'h44);
    gcnt = 0; gfirst = 0; rvcnt = 0; rvfirst = 0; rdcnt = 0; drop = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      cyc_drive();
      u_busy_early = 1'b0; u_read = 1'b0; reg_datai = 8'h66;
      if (drop) b_req = 1'b0;
      @(negedge usb_clk);
      if (reg_read) rdcnt++;
      if (b_gnt) begin gcnt++; gfirst = i; drop = 1'b1; end
      if (b_rvalid) begin rvcnt++; rvfirst = i; chk("ab_rdata", b_rdata, 8'h66); end
    end
    chk("ab_gnt_count", gcnt, 1);
    chk("ab_gnt_cycle", gfirst, 6);
    chk("ab_rvalid_count", rvcnt, 1);
    chk("ab_rvalid_cycle", rvfirst, 7);
    chk("ab_regread_count", rdcnt, 2);

    // ---------------- starvation under continuous USB ----------------
    gcnt = 0;
    for (int j = 1; j <= 300; j++) begin
      cyc_drive();
      u_busy_early = 1'b1; u_write = (j > 1) && (j % 2 == 0);
      b_req = 1'b1; b_we = 1'b1; b_address = 14'h05;
      starve_clr = (j == 280);
      @(negedge usb_clk);
      if (b_gnt) gcnt++;
      if (j == 255) chk("st_flag_255", starve_flag, 0);
      if (j == 256) chk("st_flag_256", starve_flag, 1);
      if (j == 281) chk("st_flag_setwins", starve_flag, 1);
    end
    chk("st_no_gnt", gcnt, 0);
    cyc_drive(); u_busy_early = 1'b0; u_write = 1'b0; b_req = 1'b0; starve_clr = 1'b1;
    @(negedge usb_clk); chk("st_flag_hold", starve_flag, 1);
    cyc_drive(); starve_clr = 1'b0;
    @(negedge usb_clk); chk("st_flag_clr", starve_flag, 0);
    repeat (5) @(posedge usb_clk);

    // ---------------- reset during B_RD2 ----------------
    cyc_drive(); b_req = 1'b1; b_we = 1'b0; b_address = 14'h0A; reg_datai = 8'h5A;
    @(negedge usb_clk); chk("rr_idle_rd", reg_read, 0);
    cyc_drive();
    @(negedge usb_clk); chk("rr_rd1_rd", reg_read, 1);
    cyc_drive(); rst_n = 1'b0;
    @(negedge usb_clk); chk("rr_rd2_gnt", b_gnt, 1);
    cyc_drive();
    @(negedge usb_clk);
    chk("rr_gnt", b_gnt, 0);
    chk("rr_rvalid", b_rvalid, 0);
    chk("rr_rdata", b_rdata, 0);
    chk("rr_regrd", reg_read, 0);
    chk("rr_flag", starve_flag, 0);
    gcnt = 0; rvcnt = 0; drop = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      cyc_drive();
      rst_n = 1'b1;
      if (drop) b_req = 1'b0;
      @(negedge usb_clk);
      if (b_gnt) begin gcnt++; drop = 1'b1; chk("rr_gnt_cycle", i, 3); end
      if (b_rvalid) begin rvcnt++; chk("rr_retry_rdata", b_rdata, 8'h5A); end
    end
    chk("rr_retry_gnt", gcnt, 1);
    chk("rr_retry_rvalid", rvcnt, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
